rr_arbiter_4: RTL and testbench

//  4-requester round-robin arbiter with grant hold and optional preemption.

---
 rtl/rr_arbiter_4_pkg.sv | 38 +++
 rtl/rr_arbiter_4_onehot_dec_2_4.sv | 18 +
 rtl/rr_arbiter_4.sv | 137 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// Holds the FSM state encoding, request/index types and the rotating winner search.
package rr_arbiter_4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef logic [0:NUM_REQ-1] req_vec_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // Rotate req left by start, take the lowest set position, then add start back.
    function automatic pick_t rr_pick(input req_vec_t req, input idx_t start);
        req_vec_t rot;
        pick_t    p;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[start + IDX_W'(i)];
        end
        p = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                p.found = 1'b1;
                p.idx   = start + IDX_W'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_onehot_dec_2_4.sv
// 2:4 one-hot decoder with enable; out[0] corresponds to s == 0.
// All outputs are zero when en is low.
module onehot_dec_2_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [IDX_W-1:0]   s,
    input  logic               en,
    output logic [0:NUM_REQ-1] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[s] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four clients with grant hold and MAX_HOLD preemption.
// All outputs are registered; the one-hot grant is decoded from the next winner index.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [0:NUM_REQ-1] req,
    output logic [0:NUM_REQ-1] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    idx_t               ptr_q, ptr_d;
    idx_t               gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               preempt_q, preempt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [0:NUM_REQ-1] gnt_q, gnt_d;

    idx_t     holder;
    idx_t     search_start;
    req_vec_t others;
    logic     others_any;
    pick_t    pick;
    logic     switch_c;
    logic     limit_c;

    // Holder context and winner search; in GRANT the search restarts just past the holder.
    always_comb begin
        holder       = gnt_idx_q;
        others       = req;
        others[holder] = 1'b0;
        others_any   = |others;
        search_start = (state_q == GRANT) ? holder + idx_t'(1) : ptr_q;
        pick         = rr_pick(req, search_start);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the two grant-change decisions.
    always_comb begin
        state_d  = state_q;
        switch_c = 1'b0;
        limit_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && pick.found) begin
                    state_d  = GRANT;
                    switch_c = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!req[holder]) begin
                    if (others_any) begin
                        switch_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_SAT) && others_any) begin
                    switch_c = 1'b1;
                    limit_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath next values; gnt_idx keeps its last value while idle.
    always_comb begin
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = (state_d == GRANT);
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = limit_c;
        if (switch_c) begin
            gnt_idx_d  = pick.idx;
            ptr_d      = pick.idx + idx_t'(1);
            hold_cnt_d = '0;
        end else if (state_d == GRANT) begin
            if (hold_cnt_q != CNT_SAT) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else begin
            hold_cnt_d = '0;
        end
    end

    onehot_dec_2_4 u_dec (
        .s   (gnt_idx_d),
        .en  (gnt_valid_d),
        .out (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 with MAX_HOLD = 4.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [0:3] req;
    logic [0:3] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        en  = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        int         c;

        // 1: reset with all requests up
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        step();
        step();
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_valid", 8'(gnt_valid), 8'h0);
        chk("rst_idx", 8'(gnt_idx), 8'h0);
        chk("rst_preempt", 8'(preempt), 8'h0);

        // 2: single request to client 2, then release
        rst = 1'b0;
        req = 4'b0010;
        step();
        chk("t2_gnt", 8'(gnt), 8'h2);
        chk("t2_idx", 8'(gnt_idx), 8'h2);
        chk("t2_valid", 8'(gnt_valid), 8'h1);
        req = 4'b0000;
        step();
        chk("t2_rel_gnt", 8'(gnt), 8'h0);
        chk("t2_rel_valid", 8'(gnt_valid), 8'h0);
        chk("t2_rel_idx_hold", 8'(gnt_idx), 8'h2);

        // 3: clients 0 and 3, holder drops -> direct hand-off
        do_reset();
        req = 4'b1001;
        step();
        chk("t3_gnt0", 8'(gnt), 8'h8);
        chk("t3_idx0", 8'(gnt_idx), 8'h0);
        req = 4'b0001;
        step();
        chk("t3_gnt3", 8'(gnt), 8'h1);
        chk("t3_idx3", 8'(gnt_idx), 8'h3);
        chk("t3_valid", 8'(gnt_valid), 8'h1);
        chk("t3_no_preempt", 8'(preempt), 8'h0);

        // 4: full contention rotates every 4 cycles with preempt pulses
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            c     = (k / 4) % 4;
            exp_g = 4'b1000 >> c;
            chk($sformatf("t4_gnt_k%0d", k), 8'(gnt), 8'(exp_g));
            chk($sformatf("t4_pre_k%0d", k), 8'(preempt), ((k % 4 == 0) && (k > 0)) ? 8'h1 : 8'h0);
        end
        // Lone client 1 is held indefinitely without preemption
        req = 4'b0100;
        for (int k = 0; k < 22; k++) begin
            step();
            chk($sformatf("t4_solo_gnt_k%0d", k), 8'(gnt), 8'h4);
            chk($sformatf("t4_solo_pre_k%0d", k), 8'(preempt), 8'h0);
        end
        chk("t4_solo_idx", 8'(gnt_idx), 8'h1);

        // 5: enable drop clears grant but keeps the pointer
        do_reset();
        req = 4'b0010;
        step();
        chk("t5_gnt2", 8'(gnt), 8'h2);
        en = 1'b0;
        step();
        chk("t5_en0_gnt", 8'(gnt), 8'h0);
        chk("t5_en0_valid", 8'(gnt_valid), 8'h0);
        en  = 1'b1;
        req = 4'b1111;
        step();
        chk("t5_ptr3_gnt", 8'(gnt), 8'h1);
        chk("t5_ptr3_idx", 8'(gnt_idx), 8'h3);

        // 6: reset mid-grant restores pointer to 0
        do_reset();
        req = 4'b0100;
        step();
        chk("t6_gnt1", 8'(gnt), 8'h4);
        rst = 1'b1;
        step();
        chk("t6_rst_gnt", 8'(gnt), 8'h0);
        chk("t6_rst_idx", 8'(gnt_idx), 8'h0);
        chk("t6_rst_valid", 8'(gnt_valid), 8'h0);
        rst = 1'b0;
        req = 4'b0110;
        step();
        chk("t6_after_gnt", 8'(gnt), 8'h4);
        chk("t6_after_idx", 8'(gnt_idx), 8'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
